// File: rtl/tm_pkg.sv
// Shared types and defaults for the Turing machine input front-end.
package tm_pkg;

  localparam int unsigned TM_DATA_WIDTH      = 4;
  localparam int unsigned TM_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_ARMING  = 2'd1,
    DB_PRESSED = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_t;

  // Debounce counter width; never below one bit so tiny configurations still elaborate.
  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/tm_debounce_fsm.sv
// Single-button debouncer: accepts a press or release only after
// DEBOUNCE_CYCLES consecutive stable samples, and flags each accepted press.
module tm_debounce_fsm
  import tm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = TM_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic fire
);

  localparam int unsigned      CNT_W    = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  db_state_t        state_q;
  db_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // State and stability counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; fire is asserted on the edge that enters PRESSED from ARMING.
  // The counter stops at CNT_LAST because reaching it always leaves the counting state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (raw) begin
          state_d = DB_ARMING;
          cnt_d   = CNT_ONE;
        end
      end
      DB_ARMING: begin
        if (!raw) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
          fire    = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      DB_PRESSED: begin
        if (!raw) begin
          state_d = DB_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      DB_RELEASE: begin
        if (raw) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/tm_input_conditioner.sv
// Debounces Next/Done, turns accepted presses into single-cycle strobes,
// captures the data switches on Next and locks out Next once Done is accepted.
module tm_input_conditioner
  import tm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = TM_DATA_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = TM_DEBOUNCE_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  next_raw,
  input  logic                  done_raw,
  input  logic [DATA_WIDTH-1:0] data_raw,
  output logic                  next_pulse,
  output logic                  done_pulse,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  locked
);

  logic next_fire;
  logic done_fire;
  logic done_pending;

  logic                  next_accept;
  logic                  done_accept;
  logic                  done_now;
  logic                  next_pulse_d;
  logic                  done_pulse_d;
  logic                  done_pending_d;
  logic                  locked_d;
  logic [DATA_WIDTH-1:0] data_out_d;

  tm_debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_db (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (next_raw),
    .fire   (next_fire)
  );

  tm_debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_done_db (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (done_raw),
    .fire   (done_fire)
  );

  // Lockout and ordering: a pending Done already counts as locked, and a Done
  // that coincides with an accepted Next is deferred one cycle behind it.
  always_comb begin
    next_accept    = next_fire && !locked && !done_pending;
    done_accept    = done_fire && !locked && !done_pending;
    done_now       = done_pending || (done_accept && !next_accept);
    next_pulse_d   = next_accept;
    done_pulse_d   = done_now;
    done_pending_d = done_accept && next_accept;
    locked_d       = locked || done_now;
    data_out_d     = data_out;
    if (next_accept) begin
      data_out_d = data_raw;
    end
  end

  // Output and lockout registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      next_pulse   <= 1'b0;
      done_pulse   <= 1'b0;
      done_pending <= 1'b0;
      locked       <= 1'b0;
      data_out     <= '0;
    end else begin
      next_pulse   <= next_pulse_d;
      done_pulse   <= done_pulse_d;
      done_pending <= done_pending_d;
      locked       <= locked_d;
      data_out     <= data_out_d;
    end
  end

endmodule

// File: tb/tb_tm_input_conditioner.sv
// Bench for tm_input_conditioner with DEBOUNCE_CYCLES=4: run-length reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_tm_input_conditioner;

  localparam int unsigned DW = 4;
  localparam int          DC = 4;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          next_raw = 1'b0;
  logic          done_raw = 1'b0;
  logic [DW-1:0] data_raw = '0;
  logic          next_pulse;
  logic          done_pulse;
  logic [DW-1:0] data_out;
  logic          locked;

  tm_input_conditioner #(
    .DATA_WIDTH     (DW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .next_raw  (next_raw),
    .done_raw  (done_raw),
    .data_raw  (data_raw),
    .next_pulse(next_pulse),
    .done_pulse(done_pulse),
    .data_out  (data_out),
    .locked    (locked)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted level flips after DC consecutive samples of
  // the opposite value; a 0->1 flip is a press.
  logic          m_n_acc, m_d_acc;
  int            m_n_run, m_d_run;
  logic          m_next_pulse, m_done_pulse, m_locked, m_pending;
  logic [DW-1:0] m_data;

  function automatic void deb_step(input logic acc, input int run, input logic raw,
                                   output logic acc_o, output int run_o, output logic fire_o);
    acc_o  = acc;
    run_o  = 0;
    fire_o = 1'b0;
    if (raw != acc) begin
      run_o = run + 1;
      if (run_o >= DC) begin
        acc_o  = raw;
        run_o  = 0;
        fire_o = raw;
      end
    end
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    logic na, da, nf, df, nacc, dacc, busy;
    int   nr, dr;
    if (!reset_n) begin
      m_n_acc <= 1'b0; m_d_acc <= 1'b0; m_n_run <= 0; m_d_run <= 0;
      m_next_pulse <= 1'b0; m_done_pulse <= 1'b0; m_locked <= 1'b0;
      m_pending <= 1'b0; m_data <= '0;
    end else begin
      deb_step(m_n_acc, m_n_run, next_raw, na, nr, nf);
      deb_step(m_d_acc, m_d_run, done_raw, da, dr, df);
      m_n_acc <= na; m_n_run <= nr;
      m_d_acc <= da; m_d_run <= dr;
      busy = m_locked || m_pending;
      nacc = nf && !busy;
      dacc = df && !busy;
      m_next_pulse <= nacc;
      if (nacc) m_data <= data_raw;
      m_pending    <= dacc && nacc;
      m_done_pulse <= m_pending || (dacc && !nacc);
      if (m_pending || (dacc && !nacc)) m_locked <= 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    chk("model next_pulse", 32'(next_pulse), 32'(m_next_pulse));
    chk("model done_pulse", 32'(done_pulse), 32'(m_done_pulse));
    chk("model data_out",   32'(data_out),   32'(m_data));
    chk("model locked",     32'(locked),     32'(m_locked));
  end

  // Pulse counters for the literal expectations.
  int n_cnt = 0, n_last = -1, d_cnt = 0, d_last = -1;
  always @(negedge clock) begin
    if (next_pulse) begin n_cnt++; n_last = cyc; end
    if (done_pulse) begin d_cnt++; d_last = cyc; end
  end

  task automatic clr();
    n_cnt = 0; n_last = -1; d_cnt = 0; d_last = -1;
  endtask

  task automatic drive(input logic nr, input logic dr, input logic [DW-1:0] d, input int n);
    next_raw = nr; done_raw = dr; data_raw = d;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0, 2);
    reset_n = 1'b1;
    clr();
  endtask

  int t0;

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset next_pulse", 32'(next_pulse), 32'd0);
    chk("reset done_pulse", 32'(done_pulse), 32'd0);
    chk("reset data_out",   32'(data_out),   32'd0);
    chk("reset locked",     32'(locked),     32'd0);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, '0, 2);
    clr();

    // Clean press.
    t0 = cyc;
    drive(1'b1, 1'b0, 4'hA, 10);
    drive(1'b0, 1'b0, 4'h0, 6);
    chk("clean count",   32'(n_cnt),       32'd1);
    chk("clean latency", 32'(n_last - t0), 32'd4);
    chk("clean data",    32'(data_out),    32'hA);
    chk("clean locked",  32'(locked),      32'd0);
    clr();

    // Press bounce: only the final run of four highs counts.
    drive(1'b1, 1'b0, 4'h6, 2);
    drive(1'b0, 1'b0, 4'h6, 1);
    t0 = cyc;
    drive(1'b1, 1'b0, 4'h6, 4);
    drive(1'b0, 1'b0, 4'h6, 6);
    chk("bounce count",   32'(n_cnt),       32'd1);
    chk("bounce latency", 32'(n_last - t0), 32'd4);
    chk("bounce data",    32'(data_out),    32'h6);
    clr();

    // Three-cycle glitch.
    drive(1'b1, 1'b0, 4'h2, 3);
    drive(1'b0, 1'b0, 4'h2, 6);
    chk("glitch count", 32'(n_cnt),    32'd0);
    chk("glitch data",  32'(data_out), 32'h6);
    clr();

    // Release bounce: no second pulse.
    drive(1'b1, 1'b0, 4'h7, 6);
    drive(1'b0, 1'b0, 4'h7, 1);
    drive(1'b1, 1'b0, 4'h7, 1);
    drive(1'b0, 1'b0, 4'h7, 8);
    chk("release bounce count", 32'(n_cnt), 32'd1);
    clr();
    drive(1'b1, 1'b0, 4'hC, 6);
    drive(1'b0, 1'b0, 4'hC, 6);
    chk("fresh press count", 32'(n_cnt),    32'd1);
    chk("fresh press data",  32'(data_out), 32'hC);

    // Simultaneous Next and Done.
    do_reset();
    t0 = cyc;
    drive(1'b1, 1'b1, 4'h5, 8);
    drive(1'b0, 1'b0, 4'h0, 6);
    chk("simul next count", 32'(n_cnt),       32'd1);
    chk("simul done count", 32'(d_cnt),       32'd1);
    chk("simul next time",  32'(n_last - t0), 32'd4);
    chk("simul done time",  32'(d_last - t0), 32'd5);
    chk("simul data",       32'(data_out),    32'h5);
    chk("simul locked",     32'(locked),      32'd1);

    // Done then Next.
    do_reset();
    drive(1'b1, 1'b0, 4'h9, 6);
    drive(1'b0, 1'b0, 4'h9, 6);
    clr();
    drive(1'b0, 1'b1, 4'h9, 6);
    drive(1'b0, 1'b0, 4'h9, 6);
    chk("done count",  32'(d_cnt),  32'd1);
    chk("done locked", 32'(locked), 32'd1);
    clr();
    drive(1'b1, 1'b0, 4'h3, 6);
    drive(1'b0, 1'b0, 4'h3, 6);
    chk("locked next count", 32'(n_cnt),    32'd0);
    chk("locked data",       32'(data_out), 32'h9);
    chk("locked stays",      32'(locked),   32'd1);

    // Async reset mid-ARMING.
    drive(1'b1, 1'b0, 4'hE, 2);
    #3 reset_n = 1'b0;
    #1;
    chk("arm reset locked", 32'(locked),     32'd0);
    chk("arm reset data",   32'(data_out),   32'd0);
    chk("arm reset pulse",  32'(next_pulse), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clr();
    t0 = cyc;
    repeat (8) @(negedge clock);
    chk("arm reset count",   32'(n_cnt),       32'd1);
    chk("arm reset latency", 32'(n_last - t0), 32'd4);
    chk("arm reset data2",   32'(data_out),    32'hE);

    // Async reset mid-PRESSED, button still held.
    #3 reset_n = 1'b0;
    #1;
    chk("press reset data",  32'(data_out),   32'd0);
    chk("press reset pulse", 32'(next_pulse), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clr();
    t0 = cyc;
    repeat (8) @(negedge clock);
    chk("press reset count",   32'(n_cnt),       32'd1);
    chk("press reset latency", 32'(n_last - t0), 32'd4);
    drive(1'b0, 1'b0, 4'h0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
